// File: rtl/qspi_regs_pkg.sv
// Shared definitions for the qspi_ctrl AXI4-Lite register bank: register offsets,
// response codes and the byte-strobe merge helper.
package qspi_regs_pkg;

    localparam logic [31:0] REG_ID     = 32'h0000_0000;
    localparam logic [31:0] REG_CTRL   = 32'h0000_0004;
    localparam logic [31:0] REG_STATUS = 32'h0000_0008;
    localparam logic [31:0] REG_SCR0   = 32'h0000_000C;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    // Replace only the bytes whose strobe is set; other bytes keep their old value.
    function automatic logic [31:0] wstrb_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/qspi_axil_regs.sv
// AXI4-Lite slave register bank terminating qspi_ctrl register accesses:
// read-only flash ID and status, a CTRL word fed back to the datapath, and scratch space.
module qspi_axil_regs
    import qspi_regs_pkg::*;
#(
    parameter int          NREG     = 16,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [23:0]       id_i,
    input  logic [31:0]       status_i,
    output logic [31:0]       ctrl_o,
    output logic              ctrl_wr_o
);

    localparam int                IDX_W      = $clog2(NREG);
    localparam logic [IDX_W-1:0]  ID_IDX     = REG_ID[IDX_W+1:2];
    localparam logic [IDX_W-1:0]  CTRL_IDX   = REG_CTRL[IDX_W+1:2];
    localparam logic [IDX_W-1:0]  STATUS_IDX = REG_STATUS[IDX_W+1:2];
    localparam logic [IDX_W-1:0]  SCR0_IDX   = REG_SCR0[IDX_W+1:2];
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * NREG);

    logic [31:0]       regs_r [NREG];
    logic              aw_held_r;
    logic              w_held_r;
    logic [ADDR_W-1:0] awaddr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        wstrb_r;
    logic              bvalid_r;
    axi_resp_e         bresp_r;
    logic              ctrl_wr_r;
    logic              rvalid_r;
    axi_resp_e         rresp_r;
    logic [31:0]       rdata_r;

    logic              aw_hs_s;
    logic              w_hs_s;
    logic              ar_hs_s;
    logic              commit_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              wr_err_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic              rd_err_s;
    logic [31:0]       rd_data_s;
    logic              unused_s;

    assign unused_s = ^{s_axi_awprot, s_axi_arprot};

    assign s_axi_awready = !aw_held_r && !bvalid_r;
    assign s_axi_wready  = !w_held_r && !bvalid_r;
    assign s_axi_arready = !rvalid_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rdata   = rdata_r;
    assign ctrl_o        = regs_r[CTRL_IDX];
    assign ctrl_wr_o     = ctrl_wr_r;

    assign aw_hs_s  = s_axi_awvalid && s_axi_awready;
    assign w_hs_s   = s_axi_wvalid && s_axi_wready;
    assign ar_hs_s  = s_axi_arvalid && s_axi_arready;
    assign commit_s = aw_held_r && w_held_r && !bvalid_r;
    assign wr_idx_s = awaddr_r[IDX_W+1:2];
    assign rd_idx_s = s_axi_araddr[IDX_W+1:2];

    // Write decode: out-of-range addresses and the read-only words below SCR0 (except CTRL) fail.
    always_comb begin
        wr_err_s = 1'b0;
        if (awaddr_r >= ADDR_LIMIT) begin
            wr_err_s = 1'b1;
        end else if ((wr_idx_s != CTRL_IDX) && (wr_idx_s < SCR0_IDX)) begin
            wr_err_s = 1'b1;
        end else begin
            wr_err_s = 1'b0;
        end
    end

    // Read mux; register contents are sampled before any same-edge write commit.
    always_comb begin
        rd_err_s  = (s_axi_araddr >= ADDR_LIMIT);
        rd_data_s = 32'h0000_0000;
        if (rd_err_s) begin
            rd_data_s = 32'h0000_0000;
        end else begin
            case (rd_idx_s)
                ID_IDX:     rd_data_s = {8'h00, id_i};
                STATUS_IDX: rd_data_s = status_i;
                default:    rd_data_s = regs_r[rd_idx_s];
            endcase
        end
    end

    // Write channel: hold AW/W independently, commit once both are held, then issue B.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'h0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            ctrl_wr_r <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= (i == int'(CTRL_IDX)) ? CTRL_RST : 32'h0000_0000;
            end
        end else begin
            ctrl_wr_r <= 1'b0;
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                awaddr_r  <= s_axi_awaddr;
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                wdata_r  <= s_axi_wdata;
                wstrb_r  <= s_axi_wstrb;
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
                if (!wr_err_s) begin
                    regs_r[wr_idx_s] <= wstrb_merge(regs_r[wr_idx_s], wdata_r, wstrb_r);
                    ctrl_wr_r        <= (wr_idx_s == CTRL_IDX);
                end
            end else if (bvalid_r && s_axi_bready) begin
                bvalid_r  <= 1'b0;
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
            end
        end
    end

    // Read channel: register the response on AR handshake and hold it until R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= 32'h0000_0000;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rresp_r  <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
            rdata_r  <= rd_data_s;
        end else if (rvalid_r && s_axi_rready) begin
            rvalid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qspi_axil_regs.sv
// Directed self-checking bench for qspi_axil_regs (NREG=16, CTRL_RST=0).
module tb_qspi_axil_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = 32'h0;
    logic [2:0]  awprot = 3'h0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = 32'h0;
    logic [2:0]  arprot = 3'h0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [23:0] id_i = 24'h0;
    logic [31:0] status_i = 32'h0;
    logic [31:0] ctrl_o;
    logic        ctrl_wr_o;

    int n_cmp = 0;
    int n_err = 0;
    int wr_pulses = 0;

    qspi_axil_regs #(.NREG(16), .ADDR_W(32), .CTRL_RST(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .id_i(id_i), .status_i(status_i), .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ctrl_wr_o) wr_pulses++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        logic aw_done, w_done, aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick;
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs) begin w_done = 1'b1; wvalid = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick; n++; end
        if (!bvalid) begin
            n_cmp++; n_err++;
            $display("FAIL write_timeout addr=%h bvalid=%b required=1", a, bvalid);
        end
        resp = bresp;
        bready = 1'b1; tick; bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; n = 0;
        while (!arready && n < 20) begin tick; n++; end
        tick;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin tick; n++; end
        if (!rvalid) begin
            n_cmp++; n_err++;
            $display("FAIL read_timeout addr=%h rvalid=%b required=1", a, rvalid);
        end
        d = rdata; resp = rresp;
        rready = 1'b1; tick; rready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; tick; tick; rst = 1'b0;
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            n_err++; $display("FAIL reset_handshake got=%b required=11100", {awready, wready, arready, bvalid, rvalid});
        end
        n_cmp++;
        if ({rdata, rresp, bresp} !== 36'h0) begin
            n_err++; $display("FAIL reset_resp rdata=%h rresp=%b bresp=%b required 0", rdata, rresp, bresp);
        end
        n_cmp++;
        if (ctrl_o !== 32'h0 || ctrl_wr_o !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl ctrl_o=%h ctrl_wr=%b required 0/0", ctrl_o, ctrl_wr_o);
        end
    endtask

    task automatic test_id_read;
        id_i = 24'hEF4018;
        araddr = 32'h00; arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h00EF4018 || rresp !== 2'b00 || arready !== 1'b0) begin
            n_err++; $display("FAIL id_read rvalid=%b rdata=%h rresp=%b arready=%b required 1/00EF4018/00/0",
                              rvalid, rdata, rresp, arready);
        end
        rready = 1'b1; tick; rready = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_err++; $display("FAIL id_read_done rvalid=%b arready=%b required 0/1", rvalid, arready);
        end
    endtask

    task automatic test_w_before_aw;
        logic [1:0] r; logic [31:0] d;
        axi_write(32'h0C, 32'hFFFF_FFFF, 4'hF, r);
        wdata = 32'hA5A5_1234; wstrb = 4'b0011; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        n_cmp++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            n_err++; $display("FAIL w_held wready=%b awready=%b bvalid=%b required 0/1/0", wready, awready, bvalid);
        end
        tick; tick;
        awaddr = 32'h0C; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b0) begin
            n_err++; $display("FAIL b_early bvalid=%b required=0", bvalid);
        end
        tick;
        n_cmp++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_err++; $display("FAIL b_latency bvalid=%b bresp=%b required 1/00", bvalid, bresp);
        end
        bready = 1'b1; tick; bready = 1'b0;
        axi_read(32'h0C, d, r);
        n_cmp++;
        if (d !== 32'hFFFF_1234 || r !== 2'b00) begin
            n_err++; $display("FAIL strobe_merge rdata=%h rresp=%b required FFFF1234/00", d, r);
        end
    endtask

    task automatic test_ctrl_bready;
        int p; logic stuck_ok;
        p = wr_pulses;
        awaddr = 32'h04; wdata = 32'h0000_0005; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        n_cmp++;
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || ctrl_wr_o !== 1'b0) begin
            n_err++; $display("FAIL ctrl_held awready=%b wready=%b bvalid=%b ctrl_wr=%b required 0/0/0/0",
                              awready, wready, bvalid, ctrl_wr_o);
        end
        tick;
        n_cmp++;
        if (bvalid !== 1'b1 || ctrl_wr_o !== 1'b1 || ctrl_o !== 32'h5) begin
            n_err++; $display("FAIL ctrl_commit bvalid=%b ctrl_wr=%b ctrl_o=%h required 1/1/5", bvalid, ctrl_wr_o, ctrl_o);
        end
        stuck_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (bvalid !== 1'b1 || ctrl_wr_o !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) stuck_ok = 1'b0;
        end
        n_cmp++;
        if (stuck_ok !== 1'b1) begin
            n_err++; $display("FAIL b_hold bvalid=%b ctrl_wr=%b awready=%b wready=%b required 1/0/0/0",
                              bvalid, ctrl_wr_o, awready, wready);
        end
        bready = 1'b1; tick; bready = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || wr_pulses !== p + 1) begin
            n_err++; $display("FAIL b_release bvalid=%b awready=%b wready=%b pulses=%0d required 0/1/1/%0d",
                              bvalid, awready, wready, wr_pulses - p, 1);
        end
    endtask

    task automatic test_errors;
        logic [1:0] r; logic [31:0] d; int p;
        status_i = 32'hCAFE_0042;
        axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10) begin n_err++; $display("FAIL wr_status_resp bresp=%b required=10", r); end
        axi_read(32'h08, d, r);
        n_cmp++;
        if (d !== 32'hCAFE_0042 || r !== 2'b00) begin
            n_err++; $display("FAIL status_read rdata=%h rresp=%b required CAFE0042/00", d, r);
        end
        axi_read(32'h40, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_err++; $display("FAIL oob_read rdata=%h rresp=%b required 0/10", d, r);
        end
        p = wr_pulses;
        axi_write(32'h44, 32'h0000_0077, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10 || ctrl_o !== 32'h5 || wr_pulses !== p) begin
            n_err++; $display("FAIL oob_write bresp=%b ctrl_o=%h pulses=%0d required 10/5/0", r, ctrl_o, wr_pulses - p);
        end
        axi_write(32'h00, 32'h1111_1111, 4'hF, r);
        n_cmp++;
        if (r !== 2'b10) begin n_err++; $display("FAIL wr_id_resp bresp=%b required=10", r); end
        axi_read(32'h3C, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b00) begin
            n_err++; $display("FAIL last_scratch rdata=%h rresp=%b required 0/00", d, r);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] r; logic [31:0] d; int p;
        axi_write(32'h14, 32'h1122_3344, 4'hF, r);
        axi_write(32'h14, 32'hAABB_CCDD, 4'b1010, r);
        axi_read(32'h14, d, r);
        n_cmp++;
        if (d !== 32'hAA22_CC44) begin n_err++; $display("FAIL b2b_merge rdata=%h required AA22CC44", d); end
        p = wr_pulses;
        axi_write(32'h04, 32'hFFFF_FFFF, 4'h0, r);
        n_cmp++;
        if (r !== 2'b00 || ctrl_o !== 32'h5 || wr_pulses !== p + 1) begin
            n_err++; $display("FAIL ctrl_zero_strb bresp=%b ctrl_o=%h pulses=%0d required 00/5/1", r, ctrl_o, wr_pulses - p);
        end
    endtask

    task automatic test_same_cycle;
        logic [1:0] r; logic [31:0] d;
        awaddr = 32'h10; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h10; arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h0 || bvalid !== 1'b1) begin
            n_err++; $display("FAIL raw_same_cycle rvalid=%b rdata=%h bvalid=%b required 1/0/1", rvalid, rdata, bvalid);
        end
        bready = 1'b1; rready = 1'b1; tick; bready = 1'b0; rready = 1'b0;
        axi_read(32'h10, d, r);
        n_cmp++;
        if (d !== 32'h1) begin n_err++; $display("FAIL raw_after rdata=%h required 1", d); end
    endtask

    task automatic test_reset_mid;
        logic [1:0] r; logic [31:0] d; logic quiet;
        awaddr = 32'h04; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h14; arvalid = 1'b1;
        tick;
        n_cmp++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || arready !== 1'b0 || ctrl_o !== 32'h9) begin
            n_err++; $display("FAIL pre_reset bvalid=%b rvalid=%b arready=%b ctrl_o=%h required 1/1/0/9",
                              bvalid, rvalid, arready, ctrl_o);
        end
        rst = 1'b1;
        tick;
        n_cmp++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || ctrl_o !== 32'h0 || awready !== 1'b1 || arready !== 1'b1) begin
            n_err++; $display("FAIL mid_reset bvalid=%b rvalid=%b ctrl_o=%h awready=%b arready=%b required 0/0/0/1/1",
                              bvalid, rvalid, ctrl_o, awready, arready);
        end
        arvalid = 1'b0; rst = 1'b0; bready = 1'b1; rready = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (bvalid !== 1'b0 || rvalid !== 1'b0) quiet = 1'b0;
        end
        bready = 1'b0; rready = 1'b0;
        n_cmp++;
        if (quiet !== 1'b1) begin n_err++; $display("FAIL stale_resp bvalid=%b rvalid=%b required 0/0", bvalid, rvalid); end
        axi_read(32'h0C, d, r);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL scratch_reset rdata=%h required 0", d); end
    endtask

    initial begin
        test_reset;
        test_id_read;
        test_w_before_aw;
        test_ctrl_bready;
        test_errors;
        test_back_to_back;
        test_same_cycle;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
